// File: rtl/aes_enc_iter_if.sv
// Block-in / block-out handshake bundle for aes_enc_iter.
// KW follows NR and is never set on its own.
interface aes_enc_iter_if #(
  parameter int NR = 10
);
  localparam int KW = 128 * (NR + 1);

  logic          in_valid;
  logic          in_ready;
  logic [127:0]  plain_text;
  logic [KW-1:0] expanded_key;
  logic          out_valid;
  logic          out_ready;
  logic [127:0]  cypher_text;
  logic          busy;

  modport master (
    output in_valid,
    output plain_text,
    output expanded_key,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  cypher_text,
    input  busy
  );

  modport slave (
    input  in_valid,
    input  plain_text,
    input  expanded_key,
    input  out_ready,
    output in_ready,
    output out_valid,
    output cypher_text,
    output busy
  );
endinterface

// File: rtl/aes_enc_iter.sv
// Iterative AES-128/192/256 encrypt core, one round per clock.
// Define ENC_ROUND_TAP_EN to add the per-round state tap outputs.
module aes_enc_iter #(
  parameter int NR = 10,
  parameter int KW = 128 * (NR + 1)
) (
  input  logic           clk,
  input  logic           rst_n,
  aes_enc_iter_if.slave  bus
`ifdef ENC_ROUND_TAP_EN
  ,
  output logic [127:0]   round_state,
  output logic [3:0]     round_idx,
  output logic           round_tap_valid
`endif
);

  if (!(NR == 10 || NR == 12 || NR == 14)) begin : g_bad_nr
    $error("aes_enc_iter: NR must be 10, 12 or 14");
  end

  typedef enum logic [1:0] {
    IDLE,
    ROUND,
    DONE
  } fsm_t;

  fsm_t          fsm;
  logic [3:0]    rnd;
  logic [127:0]  st;
  logic [KW-1:0] key;
  logic [127:0]  ct;
  logic          ov;
  logic          ir;
  logic          bz;

  function automatic logic [7:0] xt(
    input logic [7:0] b
  );
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(
    input logic [7:0] a,
    input logic [7:0] b
  );
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xt(x);
    end
    return p;
  endfunction

  // Inverse as x^254, then the affine map; inv(0) falls out as 0.
  function automatic logic [7:0] sbox(
    input logic [7:0] x
  );
    logic [7:0] sq;
    logic [7:0] r;
    sq = x;
    r  = 8'h01;
    for (int i = 1; i < 8; i++) begin
      sq = gmul(sq, sq);
      r  = gmul(r, sq);
    end
    return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]}
         ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [127:0] sub_bytes(
    input logic [127:0] s
  );
    logic [127:0] o;
    for (int i = 0; i < 16; i++)
      o[127-8*i -: 8] = sbox(s[127-8*i -: 8]);
    return o;
  endfunction

  // Byte 4c+r is row r of column c.
  function automatic logic [127:0] shift_rows(
    input logic [127:0] s
  );
    logic [127:0] o;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127-8*(4*c+r) -: 8] =
          s[127-8*(4*((c+r)%4)+r) -: 8];
    return o;
  endfunction

  function automatic logic [127:0] mix_columns(
    input logic [127:0] s
  );
    logic [127:0] o;
    logic [7:0]   a0, a1, a2, a3;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      o[127-32*c -: 8] = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
      o[119-32*c -: 8] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
      o[111-32*c -: 8] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
      o[103-32*c -: 8] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
    end
    return o;
  endfunction

  logic [127:0] rk [0:NR];

  for (genvar r = 0; r <= NR; r++) begin : g_rk
    assign rk[r] = key[KW-1-128*r -: 128];
  end

  logic         last;
  logic [127:0] sr;
  logic [127:0] mc;
  logic [127:0] nxt;

  always_comb begin
    last = (rnd == 4'(NR));
    sr   = shift_rows(sub_bytes(st));
    mc   = mix_columns(sr);
    nxt  = (last ? sr : mc) ^ rk[rnd];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm <= IDLE;
      rnd <= '0;
      st  <= '0;
      key <= '0;
      ct  <= '0;
      ov  <= 1'b0;
      ir  <= 1'b1;
      bz  <= 1'b0;
`ifdef ENC_ROUND_TAP_EN
      round_state     <= '0;
      round_idx       <= '0;
      round_tap_valid <= 1'b0;
`endif
    end else begin
`ifdef ENC_ROUND_TAP_EN
      round_tap_valid <= 1'b0;
`endif
      case (fsm)
        IDLE: begin
          if (bus.in_valid) begin
            key <= bus.expanded_key;
            st  <= bus.plain_text
                 ^ bus.expanded_key[KW-1 -: 128];
            rnd <= 4'd1;
            fsm <= ROUND;
            ir  <= 1'b0;
            bz  <= 1'b1;
`ifdef ENC_ROUND_TAP_EN
            round_state <= bus.plain_text
                         ^ bus.expanded_key[KW-1 -: 128];
            round_idx       <= 4'd0;
            round_tap_valid <= 1'b1;
`endif
          end
        end
        ROUND: begin
          st <= nxt;
`ifdef ENC_ROUND_TAP_EN
          round_state     <= nxt;
          round_idx       <= rnd;
          round_tap_valid <= 1'b1;
`endif
          if (last) begin
            ct  <= nxt;
            ov  <= 1'b1;
            fsm <= DONE;
          end else begin
            rnd <= rnd + 4'd1;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            ov  <= 1'b0;
            ir  <= 1'b1;
            bz  <= 1'b0;
            rnd <= '0;
            fsm <= IDLE;
          end
        end
        default: fsm <= IDLE;
      endcase
    end
  end

  assign bus.in_ready    = ir;
  assign bus.out_valid   = ov;
  assign bus.cypher_text = ct;
  assign bus.busy        = bz;

endmodule

// File: tb/tb_aes_enc_iter.sv
// Scoreboard bench for aes_enc_iter: NR=10 main instance,
// NR=12/14 instances for the longer key sizes.
module tb_aes_enc_iter;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int fails = 0;

  aes_enc_iter_if #(.NR(10)) b10 ();
  aes_enc_iter_if #(.NR(12)) b12 ();
  aes_enc_iter_if #(.NR(14)) b14 ();

`ifdef ENC_ROUND_TAP_EN
  logic [127:0] ts10, ts12, ts14;
  logic [3:0]   ti10, ti12, ti14;
  logic         tv10, tv12, tv14;
`endif

  aes_enc_iter #(.NR(10)) u10 (
    .clk(clk),
    .rst_n(rst_n),
    .bus(b10.slave)
`ifdef ENC_ROUND_TAP_EN
    ,
    .round_state(ts10),
    .round_idx(ti10),
    .round_tap_valid(tv10)
`endif
  );

  aes_enc_iter #(.NR(12)) u12 (
    .clk(clk),
    .rst_n(rst_n),
    .bus(b12.slave)
`ifdef ENC_ROUND_TAP_EN
    ,
    .round_state(ts12),
    .round_idx(ti12),
    .round_tap_valid(tv12)
`endif
  );

  aes_enc_iter #(.NR(14)) u14 (
    .clk(clk),
    .rst_n(rst_n),
    .bus(b14.slave)
`ifdef ENC_ROUND_TAP_EN
    ,
    .round_state(ts14),
    .round_idx(ti14),
    .round_tap_valid(tv14)
`endif
  );

  localparam logic [127:0] PT0 =
    128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] EXP10 =
    128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] EXP12 =
    128'hdda97ca4864cdfe06eaf70a0ec0d7191;
  localparam logic [127:0] EXP14 =
    128'h8ea2b7ca516745bfeafc49904b496089;
  localparam logic [127:0] PTB =
    128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] KB =
    128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] EXPB =
    128'h3925841d02dc09fbdc118597196a0b32;

  logic [7:0]    sb [256];
  logic [1407:0] e10, eb;
  logic [1663:0] e12;
  logic [1919:0] e14;

  task automatic chk(input string n,
                     input longint a,
                     input longint e);
    checks++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s got=%0d want=%0d", n, a, e);
    end
  endtask

  task automatic chk128(input string n,
                        input logic [127:0] a,
                        input logic [127:0] e);
    checks++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s got=%h want=%h", n, a, e);
    end
  endtask

  task automatic tout(input string n);
    checks++;
    fails++;
    $display("FAIL %s timeout", n);
  endtask

  // S-box by walking the multiplicative group (generator 3).
  task automatic build_sbox();
    logic [7:0] p, q, x;
    p = 8'h01;
    q = 8'h01;
    do begin
      p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
      q = q ^ {q[6:0], 1'b0};
      q = q ^ {q[5:0], 2'b0};
      q = q ^ {q[3:0], 4'b0};
      if (q[7]) q = q ^ 8'h09;
      x = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]}
        ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]};
      sb[p] = x ^ 8'h63;
    end while (p != 8'h01);
    sb[0] = 8'h63;
  endtask

  function automatic logic [31:0] subw(input logic [31:0] w);
    return {sb[w[31:24]], sb[w[23:16]],
            sb[w[15:8]], sb[w[7:0]]};
  endfunction

  function automatic logic [1919:0] expand(
    input logic [255:0] k,
    input int nk,
    input int nr
  );
    logic [31:0]   w [60];
    logic [31:0]   t;
    logic [7:0]    rc;
    logic [1919:0] e;
    rc = 8'h01;
    e  = '0;
    for (int i = 0; i < nk; i++) w[i] = k[255-32*i -: 32];
    for (int i = nk; i < 4*(nr+1); i++) begin
      t = w[i-1];
      if (i % nk == 0) begin
        t  = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
      end else if (nk > 6 && i % nk == 4) begin
        t = subw(t);
      end
      w[i] = w[i-nk] ^ t;
    end
    for (int i = 0; i < 4*(nr+1); i++)
      e[1919-32*i -: 32] = w[i];
    return e;
  endfunction

  logic [127:0] q10 [$];
  int           acc10 [$];

  task automatic scramble();
    b10.plain_text = {$urandom, $urandom, $urandom, $urandom};
    for (int i = 0; i < 44; i++)
      b10.expanded_key[32*i +: 32] = $urandom;
  endtask

  task automatic wait_ready();
    int n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!b10.in_ready && n < 100);
    if (!b10.in_ready) tout("wait_ready");
  endtask

  task automatic send10(input logic [127:0] pt,
                        input logic [1407:0] ek,
                        input logic [127:0] e,
                        input bit keep);
    wait_ready();
    b10.in_valid     = 1'b1;
    b10.plain_text   = pt;
    b10.expanded_key = ek;
    q10.push_back(e);
    @(posedge clk);
    #1;
    b10.in_valid = keep;
    scramble();
  endtask

  task automatic drain();
    int n = 0;
    while ((q10.size() != 0 || !b10.in_ready) && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 200) tout("drain");
  endtask

  bit ovp = 0, irp = 0;
  int tidx = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      ovp  = 0;
      irp  = 0;
      tidx = 0;
    end else begin
      chk("ir_vs_busy", b10.in_ready, !b10.busy);
      if (b10.in_valid && b10.in_ready) acc10.push_back(cyc + 1);
      if (b10.out_valid && !ovp) begin
        if (acc10.size() == 0) tout("lat_noacc");
        else chk("latency", cyc - acc10[0], 10);
      end
      if (b10.out_valid && !b10.out_ready) begin
        if (q10.size() != 0)
          chk128("stall_ct", b10.cypher_text, q10[0]);
        chk("stall_ir", b10.in_ready, 0);
      end
      if (irp) begin
        chk("ir_after_hs", b10.in_ready, 1);
        chk("ov_after_hs", b10.out_valid, 0);
        irp = 0;
      end
      if (b10.out_valid && b10.out_ready) begin
        if (q10.size() == 0) begin
          tout("unexpected_out");
        end else begin
          chk128("ct", b10.cypher_text, q10.pop_front());
          if (acc10.size() != 0) void'(acc10.pop_front());
        end
        irp = 1;
      end
      ovp = b10.out_valid;
`ifdef ENC_ROUND_TAP_EN
      if (tv10) begin
        chk("tap_idx", ti10, tidx);
        tidx = (tidx == 10) ? 0 : tidx + 1;
      end
`endif
    end
  end

  int acc12 = 0, acc14 = 0;
  bit ov12p = 0, ov14p = 0, done12 = 0, done14 = 0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (b12.in_valid && b12.in_ready) acc12 = cyc + 1;
      if (b14.in_valid && b14.in_ready) acc14 = cyc + 1;
      if (b12.out_valid && !ov12p) begin
        chk("lat12", cyc - acc12, 12);
        chk128("ct12", b12.cypher_text, EXP12);
        done12 = 1;
      end
      if (b14.out_valid && !ov14p) begin
        chk("lat14", cyc - acc14, 14);
        chk128("ct14", b14.cypher_text, EXP14);
        done14 = 1;
      end
      ov12p = b12.out_valid;
      ov14p = b14.out_valid;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1919:0] full;
    int prev;
    build_sbox();
    full = expand({128'h000102030405060708090a0b0c0d0e0f,
                   128'h0}, 4, 10);
    e10  = full[1919 -: 1408];
    full = expand({KB, 128'h0}, 4, 10);
    eb   = full[1919 -: 1408];
    full = expand({192'h000102030405060708090a0b0c0d0e0f1011121314151617,
                   64'h0}, 6, 12);
    e12  = full[1919 -: 1664];
    e14  = expand(
      256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f,
      8, 14);

    b10.in_valid = 0;
    b10.out_ready = 1;
    b10.plain_text = '0;
    b10.expanded_key = '0;
    b12.in_valid = 0;
    b12.out_ready = 1;
    b12.plain_text = '0;
    b12.expanded_key = '0;
    b14.in_valid = 0;
    b14.out_ready = 1;
    b14.plain_text = '0;
    b14.expanded_key = '0;

    #1 rst_n = 0;
    #1;
    chk("rst_ir", b10.in_ready, 1);
    chk("rst_ov", b10.out_valid, 0);
    chk("rst_busy", b10.busy, 0);
    chk128("rst_ct", b10.cypher_text, '0);
    @(negedge clk);
    @(negedge clk);
    #1 rst_n = 1;

    @(posedge clk);
    #1;
    b12.in_valid = 1;
    b12.plain_text = PT0;
    b12.expanded_key = e12;
    b14.in_valid = 1;
    b14.plain_text = PT0;
    b14.expanded_key = e14;
    send10(PT0, e10, EXP10, 0);
    b12.in_valid = 0;
    b14.in_valid = 0;
`ifdef ENC_ROUND_TAP_EN
    chk128("tap_r0", ts10,
           128'h00102030405060708090a0b0c0d0e0f0);
    chk("tap_v0", tv10, 1);
    @(posedge clk);
    #1;
    chk128("tap_r1", ts10,
           128'h89d810e8855ace682d1843d8cb128fe4);
    chk("tap_i1", ti10, 1);
`endif
    drain();
    chk128("ct_hold", b10.cypher_text, EXP10);

    // Backpressure with a competing request held on the bus.
    begin
      int n = 0;
      b10.out_ready = 0;
      send10(PTB, eb, EXPB, 1);
      while (!b10.out_valid && n < 50) begin
        @(posedge clk);
        #1;
        scramble();
        n++;
      end
      if (!b10.out_valid) tout("stall_wait");
      repeat (20) begin
        @(posedge clk);
        #1;
        scramble();
      end
      b10.out_ready = 1;
      send10(PT0, e10, EXP10, 0);
      drain();
    end

    prev = 0;
    for (int k = 0; k < 4; k++) begin
      if (k % 2 == 1) send10(PTB, eb, EXPB, 1);
      else send10(PT0, e10, EXP10, 1);
      if (k > 0) chk("ii", cyc - prev, 12);
      prev = cyc;
    end
    b10.in_valid = 0;
    drain();

    send10(PTB, eb, EXPB, 0);
    repeat (4) begin
      @(posedge clk);
      #1;
    end
    #2 rst_n = 0;
    #1;
    chk("arst_ov", b10.out_valid, 0);
    chk("arst_ir", b10.in_ready, 1);
    chk("arst_busy", b10.busy, 0);
    chk128("arst_ct", b10.cypher_text, '0);
`ifdef ENC_ROUND_TAP_EN
    chk128("arst_tap", ts10, '0);
    chk("arst_tv", tv10, 0);
`endif
    q10.delete();
    acc10.delete();
    @(negedge clk);
    #1 rst_n = 1;
    send10(PT0, e10, EXP10, 0);
    drain();

    chk("q_empty", q10.size(), 0);
    chk("done12", done12, 1);
    chk("done14", done14, 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
